// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-port register access arbiter:
// default sizes, port identifiers and the grant-state encoding.
package reg_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Grant decision for the current cycle; prio carries the history between cycles.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } grant_state_t;

endpackage

// File: rtl/reg_store.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational
// read port, cleared by synchronous reset. Out-of-range writes are dropped, reads return 0.
module reg_store
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              waddr_ok;
    logic              raddr_ok;

    // Range checks only exist when the address space has holes above DEPTH-1.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign waddr_ok = 1'b1;
            assign raddr_ok = 1'b1;
        end else begin : g_partial_range
            assign waddr_ok = (32'(waddr) < 32'(DEPTH));
            assign raddr_ok = (32'(raddr) < 32'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = raddr_ok ? mem[raddr] : '0;

endmodule

// File: rtl/reg_access_arbiter.sv
// Two-port round-robin arbiter in front of a shared register store; one
// transaction per cycle, reads answered on a registered per-port response channel.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              prio,
    output grant_state_t      dbg_state
);

    // Handshake: a request is taken at the rising edge where valid && ready.
    // ready is combinational from both valids and prio, never from the other
    // request fields; the requester holds valid/we/addr/wdata until taken.
    // Responses are fire-and-forget: rspN_valid is a one-cycle pulse, no ready.

    grant_state_t      state;
    logic              prio_next;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              store_we;
    logic [DATA_W-1:0] store_rdata;
    logic              rd0_accept;
    logic              rd1_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= PORT0;
        end else begin
            prio <= prio_next;
        end
    end

    always_comb begin
        state     = IDLE;
        prio_next = prio;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                state = (prio == PORT0) ? G0 : G1;
            end else if (req0_valid) begin
                state = G0;
            end else if (req1_valid) begin
                state = G1;
            end
        end
        // The loser of this cycle becomes the preferred port for the next.
        case (state)
            G0:      prio_next = PORT1;
            G1:      prio_next = PORT0;
            default: prio_next = prio;
        endcase
    end

    assign req0_ready = (state == G0);
    assign req1_ready = (state == G1);
    assign dbg_state  = state;

    always_comb begin
        acc_we    = req0_we;
        acc_addr  = req0_addr;
        acc_wdata = req0_wdata;
        if (state == G1) begin
            acc_we    = req1_we;
            acc_addr  = req1_addr;
            acc_wdata = req1_wdata;
        end
    end

    assign store_we   = (state != IDLE) && acc_we;
    assign rd0_accept = (state == G0) && !req0_we;
    assign rd1_accept = (state == G1) && !req1_we;

    reg_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (store_we),
        .waddr (acc_addr),
        .wdata (acc_wdata),
        .raddr (acc_addr),
        .rdata (store_rdata)
    );

    // Reset drops any response that would otherwise appear in the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= rd0_accept;
            rsp1_valid <= rd1_accept;
            if (rd0_accept) begin
                rsp0_rdata <= store_rdata;
            end
            if (rd1_accept) begin
                rsp1_rdata <= store_rdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed table-driven bench for reg_access_arbiter plus hand-written
// reset and read-back sequences.
module tb_reg_access_arbiter;
  import reg_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          prio;
  grant_state_t  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic          v0;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          rdy0;
    logic          rdy1;
    logic          rv0;
    logic [DW-1:0] rd0;
    logic          rv1;
    logic [DW-1:0] rd1;
    logic          prio;
  } vec_t;

  vec_t vecs[$];

  reg_access_arbiter #(.DATA_W(DW), .DEPTH(4), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .prio       (prio),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, got running, wanted finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0;
    req0_we    = we0;
    req0_addr  = a0;
    req0_wdata = d0;
    req1_valid = v1;
    req1_we    = we1;
    req1_addr  = a1;
    req1_wdata = d1;
  endtask

  function automatic vec_t mk(input logic v0, input logic we0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic v1, input logic we1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic rdy0, input logic rdy1,
                              input logic rv0, input logic [DW-1:0] rd0,
                              input logic rv1, input logic [DW-1:0] rd1,
                              input logic pr);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1;
    v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    v.prio = pr;
    return v;
  endfunction

  initial begin
    //            p0: v we a  data       p1: v we a  data      rdy0 rdy1 rv0 rd0       rv1 rd1       prio
    vecs.push_back(mk(1, 1, 1, 16'hA5A5, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 1)); // p0 write a1
    vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 16'hA5A5, 0, 16'h0000, 1)); // p0 read a1
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hA5A5, 0, 16'h0000, 1)); // idle, rdata held
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h1111, 0, 1, 0, 16'hA5A5, 0, 16'h0000, 0)); // p1 write a0
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 2, 16'h2222, 0, 1, 0, 16'hA5A5, 0, 16'h0000, 0)); // p1 write a2
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 3, 16'h3333, 0, 1, 0, 16'hA5A5, 0, 16'h0000, 0)); // p1 write a3
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 1, 0, 1, 16'h1111, 0, 16'h0000, 1)); // both: p0 wins
    vecs.push_back(mk(1, 0, 2, 16'h0000, 1, 0, 1, 16'h0000, 0, 1, 0, 16'h1111, 1, 16'hA5A5, 0)); // both: p1 wins
    vecs.push_back(mk(1, 0, 2, 16'h0000, 1, 0, 3, 16'h0000, 1, 0, 1, 16'h2222, 0, 16'hA5A5, 1)); // both: p0 wins
    vecs.push_back(mk(1, 0, 1, 16'h0000, 1, 0, 3, 16'h0000, 0, 1, 0, 16'h2222, 1, 16'h3333, 0)); // both: p1 wins
    vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 16'hA5A5, 0, 16'h3333, 1)); // p0 leftover
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hA5A5, 0, 16'h3333, 1)); // idle keeps prio
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 3, 16'h0000, 0, 1, 0, 16'hA5A5, 1, 16'h3333, 0)); // p1 read a3
    vecs.push_back(mk(1, 1, 2, 16'h1234, 1, 0, 2, 16'h0000, 1, 0, 0, 16'hA5A5, 0, 16'h3333, 1)); // w/r clash: p0
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 2, 16'h0000, 0, 1, 0, 16'hA5A5, 1, 16'h1234, 0)); // p1 sees new data
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'hBEEF, 0, 1, 0, 16'hA5A5, 0, 16'h1234, 0)); // p1 burst 1
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 16'hCAFE, 0, 1, 0, 16'hA5A5, 0, 16'h1234, 0)); // p1 burst 2
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 3, 16'h0F0F, 0, 1, 0, 16'hA5A5, 0, 16'h1234, 0)); // p1 burst 3
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 16'hBEEF, 0, 16'h1234, 1)); // p0 read a0
    vecs.push_back(mk(1, 0, 1, 16'h0000, 1, 0, 3, 16'h0000, 0, 1, 0, 16'hBEEF, 1, 16'h0F0F, 0)); // both: prio=1
    vecs.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 1, 16'hCAFE, 0, 16'h0F0F, 1)); // p0 read a1

    // reset with both ports requesting: nothing accepted, everything cleared
    rst = 1'b1;
    drive(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst ready0", 32'(req0_ready), 32'(0));
    check("rst ready1", 32'(req1_ready), 32'(0));
    check("rst state", 32'(dbg_state), 32'(IDLE));
    check("rst prio", 32'(prio), 32'(0));
    check("rst rsp0_valid", 32'(rsp0_valid), 32'(0));
    check("rst rsp1_valid", 32'(rsp1_valid), 32'(0));
    check("rst rsp0_rdata", 32'(rsp0_rdata), 32'(0));
    check("rst rsp1_rdata", 32'(rsp1_rdata), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("v%0d ready0", i), 32'(req0_ready), 32'(vecs[i].rdy0));
      check($sformatf("v%0d ready1", i), 32'(req1_ready), 32'(vecs[i].rdy1));
      @(posedge clk);
      #1;
      check($sformatf("v%0d rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].rv0));
      check($sformatf("v%0d rsp0_rdata", i), 32'(rsp0_rdata), 32'(vecs[i].rd0));
      check($sformatf("v%0d rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].rv1));
      check($sformatf("v%0d rsp1_rdata", i), 32'(rsp1_rdata), 32'(vecs[i].rd1));
      check($sformatf("v%0d prio", i), 32'(prio), 32'(vecs[i].prio));
    end

    // response in flight, then reset while new reads are presented
    @(negedge clk);
    drive(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0000);
    #1;
    check("flight ready0", 32'(req0_ready), 32'(1));
    @(posedge clk);
    #1;
    check("flight rsp0_valid", 32'(rsp0_valid), 32'(1));
    check("flight rsp0_rdata", 32'(rsp0_rdata), 32'(16'hCAFE));
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 16'h0000, 1, 0, 3, 16'h0000);
    #1;
    check("rst2 ready0", 32'(req0_ready), 32'(0));
    check("rst2 ready1", 32'(req1_ready), 32'(0));
    @(posedge clk);
    #1;
    check("rst2 rsp0_valid", 32'(rsp0_valid), 32'(0));
    check("rst2 rsp1_valid", 32'(rsp1_valid), 32'(0));
    check("rst2 rsp0_rdata", 32'(rsp0_rdata), 32'(0));
    check("rst2 rsp1_rdata", 32'(rsp1_rdata), 32'(0));
    check("rst2 prio", 32'(prio), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    #1;
    @(posedge clk);
    #1;
    check("rst2 no pulse", 32'(rsp0_valid), 32'(0));

    // storage must read back cleared
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      drive(1, 0, 2'(a), 16'h0000, 0, 0, 0, 16'h0000);
      @(posedge clk);
      #1;
      check($sformatf("clr a%0d valid", a), 32'(rsp0_valid), 32'(1));
      check($sformatf("clr a%0d rdata", a), 32'(rsp0_rdata), 32'(0));
    end
    @(negedge clk);
    drive(0, 0, 0, 16'h0000, 1, 0, 3, 16'h0000);
    @(posedge clk);
    #1;
    check("clr p1 a3 valid", 32'(rsp1_valid), 32'(1));
    check("clr p1 a3 rdata", 32'(rsp1_rdata), 32'(0));
    check("clr p0 idle valid", 32'(rsp0_valid), 32'(0));
    @(negedge clk);
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
